// File: rtl/fixed_pkg.sv
// Shared fixed-point number format, state encoding and sizing helpers
// for the multiplier/divider library.
package fixed_pkg;

    localparam int unsigned WIDTH_DEF = 25;
    localparam int unsigned FBITS_DEF = 21;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CALC  = 3'd2,
        ROUND = 3'd3,
        SIGN  = 3'd4
    } div_state_t;

    // Quotient width including the rounding guard bit; also the iteration count.
    function automatic int unsigned div_iter(input int unsigned width, input int unsigned fbits);
        return (width - 1) + fbits + 1;
    endfunction

endpackage

// File: rtl/div.sv
// Signed fixed-point divider: restoring long division, one quotient bit per
// clock, round-half-to-even on the result.
module div
    import fixed_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned FBITS = FBITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    valid,
    output logic                    dbz,
    output logic                    ovf,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] val
);

    localparam int unsigned WU = WIDTH - 1;
    localparam int unsigned QW = div_iter(WIDTH, FBITS);
    localparam int unsigned CW = $clog2(QW + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {WU{1'b0}}};

    div_state_t               state;
    logic signed [WIDTH-1:0]  a_r;
    logic signed [WIDTH-1:0]  b_r;
    logic                     sig_diff;
    logic        [WU-1:0]     b_mag;
    logic        [QW-1:0]     dvd;
    logic        [WU:0]       rem;
    logic        [CW-1:0]     cnt;
    logic        [WU-1:0]     qr;

    logic        [WU-1:0]     a_mag_c;
    logic        [WU-1:0]     b_mag_c;
    logic        [WU:0]       rem_sh_c;
    logic                     fits_c;
    logic        [WU:0]       rem_nx_c;
    logic        [QW-2:0]     q_c;
    logic                     rnd_c;
    logic        [QW-1:0]     qr_full_c;
    logic                     qr_ovf_c;

    // Magnitudes, one restoring step, and the rounding of the extended quotient.
    always_comb begin
        a_mag_c   = a_r[WIDTH-1] ? WU'(-a_r) : a_r[WU-1:0];
        b_mag_c   = b_r[WIDTH-1] ? WU'(-b_r) : b_r[WU-1:0];
        rem_sh_c  = {rem[WU-1:0], dvd[QW-1]};
        fits_c    = rem_sh_c >= {1'b0, b_mag};
        rem_nx_c  = fits_c ? (rem_sh_c - {1'b0, b_mag}) : rem_sh_c;
        q_c       = dvd[QW-1:1];
        rnd_c     = dvd[0] & ((rem != '0) | q_c[0]);
        qr_full_c = {1'b0, q_c} + QW'(rnd_c);
        qr_ovf_c  = qr_full_c[QW-1:WU] != '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            dbz      <= 1'b0;
            ovf      <= 1'b0;
            val      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            sig_diff <= 1'b0;
            b_mag    <= '0;
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            qr       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        sig_diff <= a[WIDTH-1] ^ b[WIDTH-1];
                        busy     <= 1'b1;
                        valid    <= 1'b0;
                        dbz      <= 1'b0;
                        ovf      <= 1'b0;
                        state    <= INIT;
                    end
                end
                INIT: begin
                    if (b_r == '0) begin
                        dbz   <= 1'b1;
                        valid <= 1'b0;
                        val   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (a_r == MOST_NEG || b_r == MOST_NEG) begin
                        // Magnitude of the most negative value does not fit in WU bits.
                        ovf   <= 1'b1;
                        valid <= 1'b0;
                        val   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        b_mag <= b_mag_c;
                        dvd   <= QW'(a_mag_c) << (FBITS + 1);
                        rem   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Dividend bits shift out the top while quotient bits fill the bottom.
                    dvd <= {dvd[QW-2:0], fits_c};
                    rem <= rem_nx_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(QW - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    ovf   <= qr_ovf_c;
                    qr    <= qr_full_c[WU-1:0];
                    state <= SIGN;
                end
                SIGN: begin
                    if (ovf) begin
                        val   <= '0;
                        valid <= 1'b0;
                    end else begin
                        val   <= sig_diff ? -WIDTH'(qr) : WIDTH'(qr);
                        valid <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for the fixed-point divider against an arithmetic
// round-half-to-even reference model.
module tb_div;

    localparam int unsigned WIDTH = 25;
    localparam int unsigned FBITS = 21;
    localparam int          LAT_NORMAL = 49;
    localparam int          LAT_SHORT  = 1;
    localparam int          TIMEOUT    = 200;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    busy, done, valid, dbz, ovf;
    logic signed [WIDTH-1:0] a = '0;
    logic signed [WIDTH-1:0] b = '0;
    logic signed [WIDTH-1:0] val;

    int errors = 0;
    int checks = 0;

    div #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .valid(valid), .dbz(dbz), .ovf(ovf), .a(a), .b(b), .val(val)
    );

    always #5 clk = ~clk;

    // Reference: exact a*2^FBITS/b rounded half-to-even, range-checked.
    function automatic void ref_div(input longint ai, input longint bi, output longint rv,
                                    output bit rovf, output bit rdbz, output int rlat);
        longint n, d, q, r;
        longint lim;
        lim  = longint'(1) <<< (WIDTH - 1);
        rv   = 0;
        rovf = 1'b0;
        rdbz = 1'b0;
        rlat = LAT_NORMAL;
        if (bi == 0) begin
            rdbz = 1'b1;
            rlat = LAT_SHORT;
        end else if (ai == -lim || bi == -lim) begin
            rovf = 1'b1;
            rlat = LAT_SHORT;
        end else begin
            n = (ai < 0 ? -ai : ai) <<< FBITS;
            d = (bi < 0 ? -bi : bi);
            q = n / d;
            r = n % d;
            if (2 * r > d || (2 * r == d && q[0])) q = q + 1;
            if (q >= lim) rovf = 1'b1;
            else rv = ((ai < 0) != (bi < 0)) ? -q : q;
        end
    endfunction

    // Launch one operation and wait (bounded) for done; cycles counts edges after the start edge.
    task automatic run_op(input logic signed [WIDTH-1:0] ai, input logic signed [WIDTH-1:0] bi,
                          output int cycles, output int busy_gaps);
        @(negedge clk);
        a = ai;
        b = bi;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cycles = 0;
        busy_gaps = 0;
        while (cycles < TIMEOUT) begin
            @(posedge clk);
            #1 cycles++;
            if (done) break;
            if (!busy) busy_gaps++;
        end
    endtask

    task automatic check_op(input string tag, input logic signed [WIDTH-1:0] ai,
                            input logic signed [WIDTH-1:0] bi);
        int cyc, gaps, elat;
        longint ev;
        bit eovf, edbz;
        ref_div(longint'(ai), longint'(bi), ev, eovf, edbz, elat);
        run_op(ai, bi, cyc, gaps);
        checks++;
        if (cyc !== elat || done !== 1'b1) begin
            errors++;
            $display("FAIL %s latency a=%h b=%h: got %0d cycles done=%b, want %0d", tag, ai, bi, cyc, done, elat);
        end
        checks++;
        if (val !== WIDTH'(ev)) begin
            errors++;
            $display("FAIL %s val a=%h b=%h: got %h, want %h", tag, ai, bi, val, WIDTH'(ev));
        end
        checks++;
        if (valid !== !(eovf || edbz) || ovf !== eovf || dbz !== edbz) begin
            errors++;
            $display("FAIL %s flags a=%h b=%h: got valid=%b ovf=%b dbz=%b, want %b %b %b",
                     tag, ai, bi, valid, ovf, dbz, !(eovf || edbz), eovf, edbz);
        end
        checks++;
        if (gaps != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy a=%h b=%h: got %0d low cycles, busy at done=%b, want 0 and 0", tag, ai, bi, gaps, busy);
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, valid, dbz, ovf} !== 5'b0 || val !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b dbz=%b ovf=%b val=%h, want all 0",
                     busy, done, valid, dbz, ovf, val);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        check_op("basic_3_div_2", 25'sh0600000, 25'sh0400000);
        checks++;
        if (val !== 25'sh0300000) begin
            errors++;
            $display("FAIL basic_const: got %h, want 0300000", val);
        end
        check_op("neg_1_div_4", -25'sh0200000, 25'sh0800000);
        checks++;
        if (val !== -25'sh0080000) begin
            errors++;
            $display("FAIL neg_const: got %h, want %h", val, -25'sh0080000);
        end
    endtask

    task automatic test_rounding();
        check_op("tie_even_down", 25'sd1, 25'sh0400000);
        checks++;
        if (val !== 25'sd0) begin
            errors++;
            $display("FAIL tie_even_const: got %h, want 0", val);
        end
        check_op("tie_odd_up", 25'sd3, 25'sh0400000);
        checks++;
        if (val !== 25'sd2) begin
            errors++;
            $display("FAIL tie_up_const: got %h, want 2", val);
        end
        check_op("neg_tie", -25'sd3, 25'sh0400000);
        check_op("neg_zero", -25'sd1, 25'sh0400000);
    endtask

    task automatic test_dbz_ovf();
        check_op("dbz", 25'sh0200000, 25'sd0);
        check_op("ovf_big", 25'sh0FFFFFF, 25'sd1);
        check_op("ovf_most_neg_a", -25'sh1000000, 25'sd5);
        check_op("ovf_most_neg_b", 25'sd5, -25'sh1000000);
        check_op("most_neg_result", -25'sh0100000, 25'sd1 <<< 16);
    endtask

    task automatic test_ignore_start();
        int dones;
        logic signed [WIDTH-1:0] seen;
        dones = 0;
        seen = '0;
        @(negedge clk);
        a = 25'sh0600000;
        b = 25'sh0400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        a = 25'sh0100000;
        b = 25'sd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                seen = val;
            end
        end
        checks++;
        if (dones != 1 || seen !== 25'sh0300000) begin
            errors++;
            $display("FAIL ignore_start: got %0d done pulses val=%h, want 1 and 0300000", dones, seen);
        end
    endtask

    task automatic test_async_reset();
        int dones;
        dones = 0;
        @(negedge clk);
        a = 25'sh0600000;
        b = 25'sh0400000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || val !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b valid=%b val=%h, want 0 0 0 0", busy, done, valid, val);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d done pulses, want 0", dones);
        end
        check_op("after_reset", 25'sh0600000, 25'sh0400000);
    endtask

    task automatic test_random();
        logic signed [WIDTH-1:0] ra, rb;
        for (int i = 0; i < 30; i++) begin
            ra = WIDTH'($urandom) >>> $urandom_range(0, 12);
            rb = WIDTH'($urandom) >>> $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
            check_op("random", ra, rb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_dbz_ovf();
        test_ignore_start();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
